// File: rtl/accel_pkg.sv
// accel_pkg: shared widths, FSM states, saturation helper and default thresholds for the shot detector
package accel_pkg;
  localparam int SAMPLE_W = 12;
  localparam int SHOT_THRESH_DEF = 300;
  localparam int REARM_THRESH_DEF = 100;
  localparam int SHOT_TIMEOUT_DEF = 200;
  localparam int COOLDOWN_SAMPLES_DEF = 8;
  typedef enum logic [1:0] {CAL = 2'd0, IDLE = 2'd1, RISE = 2'd2, COOLDOWN = 2'd3} state_t;
  function automatic logic signed [SAMPLE_W-1:0] sat12(input logic signed [SAMPLE_W:0] v);
    return (v[SAMPLE_W] != v[SAMPLE_W-1]) ? (v[SAMPLE_W] ? 12'sh800 : 12'sh7FF) : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/accel_shot_detector_if.sv
// accel_shot_detector_if: raw X/Y sample words and strobes from the ADXL362 reader (master drives, slave consumes)
interface accel_shot_detector_if;
  logic [15:0] x_raw;
  logic [15:0] y_raw;
  logic x_valid;
  logic y_valid;
  modport master(output x_raw, x_valid, y_raw, y_valid);
  modport slave(input x_raw, x_valid, y_raw, y_valid);
endinterface

// File: rtl/axis_moving_avg.sv
// axis_moving_avg: power-of-2 window moving average of signed 12-bit samples, one-cycle latency
// Ports: iclk, rst (sync, active high), clr (zero window), in_valid/in_data, out_valid/out_data
module axis_moving_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic               iclk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic signed [11:0] in_data,
  output logic               out_valid,
  output logic signed [11:0] out_data
);
  localparam int N = 1 << AVG_LOG2;
  localparam int SW = 12 + AVG_LOG2;
  logic signed [11:0] win [N];
  logic signed [SW-1:0] sum, sum_n;
  assign sum_n = sum + SW'(in_data) - SW'(win[N-1]);
  always_ff @(posedge iclk) begin
    if (rst || clr) begin
      win <= '{default: '0};
      sum <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        win[0] <= in_data;
        for (int i = 1; i < N; i++) win[i] <= win[i-1];
        sum <= sum_n;
        out_data <= 12'(sum_n >>> AVG_LOG2);
      end
    end
  end
endmodule

// File: rtl/accel_shot_detector.sv
// accel_shot_detector: zero-offset calibration, per-axis moving average and flick FSM emitting shot events
// Ports: iclk, rst (sync, active high); bus (slave: x_raw/x_valid, y_raw/y_valid);
//   x_filt/y_filt/filt_valid filtered pair; cal_done; shot_pulse/shot_power/shot_angle; state_dbg.
// Macro ACCEL_RECAL_EN adds input recal: restarts calibration without touching the last shot values.
module accel_shot_detector
  import accel_pkg::*;
#(
  parameter int CAL_LOG2 = 4,
  parameter int AVG_LOG2 = 2,
  parameter int SHOT_THRESH = SHOT_THRESH_DEF,
  parameter int REARM_THRESH = REARM_THRESH_DEF,
  parameter int SHOT_TIMEOUT = SHOT_TIMEOUT_DEF,
  parameter int COOLDOWN_SAMPLES = COOLDOWN_SAMPLES_DEF
) (
  input  logic                       iclk,
  input  logic                       rst,
`ifdef ACCEL_RECAL_EN
  input  logic                       recal,
`endif
  accel_shot_detector_if.slave       bus,
  output logic signed [SAMPLE_W-1:0] x_filt,
  output logic signed [SAMPLE_W-1:0] y_filt,
  output logic                       filt_valid,
  output logic                       cal_done,
  output logic                       shot_pulse,
  output logic signed [SAMPLE_W-1:0] shot_power,
  output logic signed [SAMPLE_W-1:0] shot_angle,
  output logic [1:0]                 state_dbg
);
  localparam int ACC_W = SAMPLE_W + CAL_LOG2;
  localparam int TW = $clog2(SHOT_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN_SAMPLES + 1);
  localparam logic signed [SAMPLE_W-1:0] SHOT_T = SAMPLE_W'(SHOT_THRESH);
  localparam logic signed [SAMPLE_W-1:0] REARM_T = SAMPLE_W'(REARM_THRESH);
  logic recal_i, x_pending, pair, cal_fin, s1_valid, fx_valid, pulse_n, unused_hi;
  logic signed [SAMPLE_W-1:0] x_lat, px, py, off_x, off_y, d_x, d_y;
  logic signed [SAMPLE_W-1:0] peak, peak_n, angle, angle_n;
  logic signed [ACC_W-1:0] acc_x, acc_y, sum_x, sum_y;
  logic [CAL_LOG2-1:0] cal_cnt;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
`ifdef ACCEL_RECAL_EN
  assign recal_i = recal;
`else
  assign recal_i = 1'b0;
`endif
  assign unused_hi = ^{bus.x_raw[15:12], bus.y_raw[15:12], fx_valid};
  // a same-cycle x strobe wins over the latched x
  assign px = bus.x_valid ? bus.x_raw[11:0] : x_lat;
  assign py = bus.y_raw[11:0];
  assign pair = bus.y_valid && (x_pending || bus.x_valid);
  assign cal_fin = pair && !cal_done && (cal_cnt == '1);
  assign sum_x = acc_x + ACC_W'(px);
  assign sum_y = acc_y + ACC_W'(py);
  assign state_dbg = state;
  always_ff @(posedge iclk) begin
    if (rst || recal_i) begin
      x_pending <= 1'b0;
      x_lat <= '0;
      acc_x <= '0;
      acc_y <= '0;
      cal_cnt <= '0;
      off_x <= '0;
      off_y <= '0;
      cal_done <= 1'b0;
      s1_valid <= 1'b0;
      d_x <= '0;
      d_y <= '0;
    end else begin
      if (bus.x_valid) x_lat <= px;
      x_pending <= (bus.x_valid || x_pending) && !bus.y_valid;
      if (pair && !cal_done) begin
        acc_x <= sum_x;
        acc_y <= sum_y;
        cal_cnt <= cal_cnt + 1'b1;
      end
      if (cal_fin) begin
        off_x <= SAMPLE_W'(sum_x >>> CAL_LOG2);
        off_y <= SAMPLE_W'(sum_y >>> CAL_LOG2);
        cal_done <= 1'b1;
      end
      s1_valid <= pair && cal_done;
      if (pair && cal_done) begin
        d_x <= sat12(13'(px) - 13'(off_x));
        d_y <= sat12(13'(py) - 13'(off_y));
      end
    end
  end
  axis_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
    .iclk(iclk), .rst(rst), .clr(cal_fin || recal_i), .in_valid(s1_valid), .in_data(d_x),
    .out_valid(fx_valid), .out_data(x_filt)
  );
  axis_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
    .iclk(iclk), .rst(rst), .clr(cal_fin || recal_i), .in_valid(s1_valid), .in_data(d_y),
    .out_valid(filt_valid), .out_data(y_filt)
  );
  always_comb begin
    state_n = state;
    peak_n = peak;
    angle_n = angle;
    timer_n = timer;
    cnt_n = cnt;
    pulse_n = 1'b0;
    if (state == CAL) state_n = cal_fin ? IDLE : CAL;
    else if (filt_valid) begin
      if (state == IDLE && y_filt >= SHOT_T) begin
        state_n = RISE;
        peak_n = y_filt;
        angle_n = x_filt;
        timer_n = '0;
      end
      if (state == RISE) begin
        timer_n = timer + 1'b1;
        if (y_filt > peak) begin
          peak_n = y_filt;
          angle_n = x_filt;
        end
        if (y_filt < REARM_T) begin
          pulse_n = 1'b1;
          state_n = COOLDOWN;
          cnt_n = '0;
        end else if (timer == TW'(SHOT_TIMEOUT - 1)) begin
          state_n = COOLDOWN;
          cnt_n = '0;
        end
      end
      if (state == COOLDOWN) begin
        cnt_n = (y_filt < REARM_T) ? cnt + 1'b1 : '0;
        state_n = (cnt_n == CW'(COOLDOWN_SAMPLES)) ? IDLE : COOLDOWN;
      end
    end
  end
  always_ff @(posedge iclk) begin
    if (rst || recal_i) begin
      state <= CAL;
      peak <= '0;
      angle <= '0;
      timer <= '0;
      cnt <= '0;
      shot_pulse <= 1'b0;
    end else begin
      state <= state_n;
      peak <= peak_n;
      angle <= angle_n;
      timer <= timer_n;
      cnt <= cnt_n;
      shot_pulse <= pulse_n;
    end
  end
  // shot results survive recalibration, only rst clears them
  always_ff @(posedge iclk) begin
    if (rst) begin
      shot_power <= '0;
      shot_angle <= '0;
    end else if (pulse_n && !recal_i) begin
      shot_power <= peak;
      shot_angle <= angle;
    end
  end
endmodule

// File: tb/tb_accel_shot_detector.sv
// tb_accel_shot_detector: directed self-checking bench for accel_shot_detector
module tb_accel_shot_detector;
  logic iclk = 1'b0;
  logic rst = 1'b1;
  always #5 iclk = ~iclk;
  accel_shot_detector_if bus();
  logic signed [11:0] x_filt, y_filt, shot_power, shot_angle;
  logic filt_valid, cal_done, shot_pulse;
  logic [1:0] state_dbg;
`ifdef ACCEL_RECAL_EN
  logic recal = 1'b0;
`endif
  accel_shot_detector dut (
    .iclk(iclk),
    .rst(rst),
`ifdef ACCEL_RECAL_EN
    .recal(recal),
`endif
    .bus(bus),
    .x_filt(x_filt),
    .y_filt(y_filt),
    .filt_valid(filt_valid),
    .cal_done(cal_done),
    .shot_pulse(shot_pulse),
    .shot_power(shot_power),
    .shot_angle(shot_angle),
    .state_dbg(state_dbg)
  );
  int pass_cnt = 0;
  int total = 0;
  int pulses = 0;
  int fvs = 0;
  always @(negedge iclk) begin
    if (shot_pulse) pulses++;
    if (filt_valid) fvs++;
  end
  function automatic logic [15:0] xdat(input int d);
    return 16'(d + 16);
  endfunction
  function automatic logic [15:0] ydat(input int d);
    return 16'(d - 16);
  endfunction
  task automatic pair(input logic [15:0] x, input logic [15:0] y);
    @(posedge iclk); #1;
    bus.x_raw = x;
    bus.x_valid = 1'b1;
    @(posedge iclk); #1;
    bus.x_valid = 1'b0;
    bus.y_raw = y;
    bus.y_valid = 1'b1;
    @(posedge iclk); #1;
    bus.y_valid = 1'b0;
    repeat (6) @(posedge iclk);
    #1;
  endtask
  task automatic test_reset;
    bus.x_raw = '0;
    bus.y_raw = '0;
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge iclk);
    #1 rst = 1'b0;
    @(negedge iclk);
    total++;
    if ({x_filt, y_filt, filt_valid, cal_done, shot_pulse, shot_power, shot_angle, state_dbg} !== '0)
      $display("FAIL reset_outputs: got x=%0d y=%0d fv=%b cd=%b sp=%b pw=%0d an=%0d st=%0d, want all 0",
               x_filt, y_filt, filt_valid, cal_done, shot_pulse, shot_power, shot_angle, state_dbg);
    else pass_cnt++;
  endtask
  task automatic test_calibration;
    for (int i = 0; i < 15; i++) pair(16'h0010, 16'hFFF0);
    total++;
    if (cal_done !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL cal_early: cal_done=%b state=%0d, want 0/0 after 15 pairs", cal_done, state_dbg);
    else pass_cnt++;
    pair(16'h0010, 16'hFFF0);
    total++;
    if (cal_done !== 1'b1 || state_dbg !== 2'd1)
      $display("FAIL cal_done: cal_done=%b state=%0d, want 1/1", cal_done, state_dbg);
    else pass_cnt++;
    total++;
    if (fvs !== 0) $display("FAIL cal_no_filt: filt_valid count %0d, want 0", fvs);
    else pass_cnt++;
    @(posedge iclk); #1;
    bus.x_raw = 16'h0010;
    bus.x_valid = 1'b1;
    @(posedge iclk); #1;
    bus.x_valid = 1'b0;
    bus.y_raw = 16'hFFF0;
    bus.y_valid = 1'b1;
    @(posedge iclk); #1;
    bus.y_valid = 1'b0;
    total++;
    if (filt_valid !== 1'b0) $display("FAIL filt_lat1: filt_valid=%b one cycle after y_valid, want 0", filt_valid);
    else pass_cnt++;
    @(posedge iclk); #1;
    total++;
    if (filt_valid !== 1'b1 || x_filt !== 12'sd0 || y_filt !== 12'sd0)
      $display("FAIL filt_lat2: fv=%b x=%0d y=%0d two cycles after y_valid, want 1/0/0", filt_valid, x_filt, y_filt);
    else pass_cnt++;
    @(posedge iclk); #1;
    total++;
    if (filt_valid !== 1'b0) $display("FAIL filt_width: filt_valid=%b, want 0", filt_valid);
    else pass_cnt++;
    repeat (6) @(posedge iclk);
    #1;
  endtask
  task automatic test_pairing;
    int f0;
    f0 = fvs;
    @(posedge iclk); #1;
    bus.y_raw = ydat(400);
    bus.y_valid = 1'b1;
    @(posedge iclk); #1;
    bus.y_valid = 1'b0;
    repeat (8) @(posedge iclk);
    #1;
    total++;
    if (fvs !== f0 || y_filt !== 12'sd0) $display("FAIL lone_y: filt_valid count %0d y=%0d, want %0d/0", fvs, y_filt, f0);
    else pass_cnt++;
    @(posedge iclk); #1;
    bus.x_raw = xdat(40);
    bus.x_valid = 1'b1;
    bus.y_raw = ydat(0);
    bus.y_valid = 1'b1;
    @(posedge iclk); #1;
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
    repeat (8) @(posedge iclk);
    #1;
    total++;
    if (fvs !== f0 + 1 || x_filt !== 12'sd10) $display("FAIL same_cycle_xy: count %0d x=%0d, want %0d/10", fvs, x_filt, f0 + 1);
    else pass_cnt++;
    @(posedge iclk); #1;
    bus.x_raw = xdat(100);
    bus.x_valid = 1'b1;
    @(posedge iclk); #1;
    bus.x_raw = xdat(200);
    @(posedge iclk); #1;
    bus.x_valid = 1'b0;
    bus.y_raw = ydat(0);
    bus.y_valid = 1'b1;
    @(posedge iclk); #1;
    bus.y_valid = 1'b0;
    repeat (8) @(posedge iclk);
    #1;
    total++;
    if (x_filt !== 12'sd60) $display("FAIL double_x: x=%0d, want 60", x_filt);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) pair(xdat(0), ydat(0));
    total++;
    if (x_filt !== 12'sd0 || state_dbg !== 2'd1) $display("FAIL flush: x=%0d st=%0d, want 0/1", x_filt, state_dbg);
    else pass_cnt++;
  endtask
  task automatic test_step_shot;
    int exp_y [8] = '{100, 200, 300, 400, 300, 200, 100, 0};
    int p0;
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      pair(xdat(50), ydat(i < 4 ? 400 : 0));
      total++;
      if (y_filt !== 12'(exp_y[i])) $display("FAIL step_y%0d: y=%0d, want %0d", i, y_filt, exp_y[i]);
      else pass_cnt++;
      if (i == 2) begin
        total++;
        if (state_dbg !== 2'd2) $display("FAIL rise_enter: st=%0d, want 2", state_dbg);
        else pass_cnt++;
      end
      if (i == 6) begin
        total++;
        if (pulses !== p0) $display("FAIL early_pulse: pulses=%0d, want %0d", pulses, p0);
        else pass_cnt++;
      end
    end
    total++;
    if (pulses !== p0 + 1 || shot_power !== 12'sd400 || shot_angle !== 12'sd50 || state_dbg !== 2'd3)
      $display("FAIL shot: pulses=%0d power=%0d angle=%0d st=%0d, want %0d/400/50/3",
               pulses, shot_power, shot_angle, state_dbg, p0 + 1);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) pair(xdat(0), ydat(0));
    total++;
    if (state_dbg !== 2'd3) $display("FAIL cool7: st=%0d, want 3", state_dbg);
    else pass_cnt++;
    pair(xdat(0), ydat(0));
    total++;
    if (state_dbg !== 2'd1 || shot_power !== 12'sd400) $display("FAIL cool8: st=%0d power=%0d, want 1/400", state_dbg, shot_power);
    else pass_cnt++;
  endtask
  task automatic test_timeout_cooldown;
    int p0;
    p0 = pulses;
    for (int i = 0; i < 150; i++) pair(xdat(0), ydat(400));
    total++;
    if (state_dbg !== 2'd2 || y_filt !== 12'sd400) $display("FAIL hold_rise: st=%0d y=%0d, want 2/400", state_dbg, y_filt);
    else pass_cnt++;
    for (int i = 0; i < 100; i++) pair(xdat(0), ydat(400));
    total++;
    if (state_dbg !== 2'd3 || pulses !== p0) $display("FAIL timeout: st=%0d pulses=%0d, want 3/%0d", state_dbg, pulses, p0);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) pair(xdat(0), ydat(0));
    total++;
    if (state_dbg !== 2'd3 || y_filt !== 12'sd0) $display("FAIL low7: st=%0d y=%0d, want 3/0", state_dbg, y_filt);
    else pass_cnt++;
    pair(xdat(0), ydat(400));
    total++;
    if (y_filt !== 12'sd100 || state_dbg !== 2'd3) $display("FAIL high1: y=%0d st=%0d, want 100/3", y_filt, state_dbg);
    else pass_cnt++;
    pair(xdat(0), ydat(-400));
    for (int i = 0; i < 6; i++) pair(xdat(0), ydat(0));
    total++;
    if (state_dbg !== 2'd3) $display("FAIL low_post7: st=%0d, want 3", state_dbg);
    else pass_cnt++;
    pair(xdat(0), ydat(0));
    total++;
    if (state_dbg !== 2'd1 || y_filt !== 12'sd0 || pulses !== p0)
      $display("FAIL rearm: st=%0d y=%0d pulses=%0d, want 1/0/%0d", state_dbg, y_filt, pulses, p0);
    else pass_cnt++;
  endtask
  task automatic test_saturation;
    int exp_y [4] = '{511, 1023, 1535, 2047};
    for (int i = 0; i < 4; i++) begin
      pair(xdat(0), 16'h07FF);
      total++;
      if (y_filt !== 12'(exp_y[i])) $display("FAIL sat%0d: y=%0d, want %0d", i, y_filt, exp_y[i]);
      else pass_cnt++;
    end
    total++;
    if (state_dbg !== 2'd2) $display("FAIL sat_rise: st=%0d, want 2", state_dbg);
    else pass_cnt++;
  endtask
  task automatic test_reset_in_rise;
    int p0;
    p0 = pulses;
    @(posedge iclk); #1 rst = 1'b1;
    @(posedge iclk); #1 rst = 1'b0;
    @(negedge iclk);
    total++;
    if ({x_filt, y_filt, filt_valid, cal_done, shot_pulse, shot_power, shot_angle, state_dbg} !== '0)
      $display("FAIL rise_reset: x=%0d y=%0d fv=%b cd=%b sp=%b pw=%0d an=%0d st=%0d, want all 0",
               x_filt, y_filt, filt_valid, cal_done, shot_pulse, shot_power, shot_angle, state_dbg);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) pair(16'h0010, 16'hFFF0);
    total++;
    if (cal_done !== 1'b0) $display("FAIL recal_early: cal_done=%b, want 0", cal_done);
    else pass_cnt++;
    pair(16'h0010, 16'hFFF0);
    pair(16'h0010, 16'hFFF0);
    total++;
    if (cal_done !== 1'b1 || state_dbg !== 2'd1 || y_filt !== 12'sd0 || pulses !== p0)
      $display("FAIL recal_done: cd=%b st=%0d y=%0d pulses=%0d, want 1/1/0/%0d", cal_done, state_dbg, y_filt, pulses, p0);
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_calibration();
    test_pairing();
    test_step_shot();
    test_timeout_cooldown();
    test_saturation();
    test_reset_in_rise();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
